// File: rtl/powlib_sfifo.sv
// powlib_sfifo: single-clock FIFO on a dual-port memory with valid/ready
// handshakes, occupancy count and programmable almost-full/almost-empty flags.
// Depth D need not be a power of two; pointers wrap explicitly at D-1.
// Optional feature: define POWLIB_SFIFO_ERR_EN to enable the sticky overflow
// flag on err (tied low otherwise).
module powlib_sfifo #(
  parameter int W      = 32,
  parameter int D      = 8,
  parameter int WIDX   = $clog2(D),
  parameter int AFULL  = D - 1,
  parameter int AEMPTY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy,
  output logic [WIDX:0] cnt,
  output logic          afull,
  output logic          aempty,
  output logic          err
);

  localparam logic [WIDX:0]   CNT_FULL   = (WIDX + 1)'(D);
  localparam logic [WIDX:0]   CNT_AFULL  = (WIDX + 1)'(AFULL);
  localparam logic [WIDX:0]   CNT_AEMPTY = (WIDX + 1)'(AEMPTY);
  localparam logic [WIDX-1:0] PTR_LAST   = WIDX'(D - 1);

  logic [W-1:0]    mem [D];
  logic [WIDX-1:0] wrptr;
  logic [WIDX-1:0] rdptr;
  logic            push;
  logic            pop;

  // Handshake and flag decode from registered count only
  always_comb begin
    wrrdy  = rst && (cnt != CNT_FULL);
    rdvld  = rst && (cnt != '0);
    push   = wrvld && wrrdy;
    pop    = rdvld && rdrdy;
    afull  = (cnt >= CNT_AFULL);
    aempty = (cnt <= CNT_AEMPTY);
    rddata = mem[rdptr];
  end

  // Storage write; contents deliberately not reset, flushed writes dropped
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wrptr] <= wrdata;
    end
  end

  // Pointer and occupancy state; clr overrides any transfer in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrptr <= '0;
      rdptr <= '0;
      cnt   <= '0;
    end else if (clr) begin
      wrptr <= '0;
      rdptr <= '0;
      cnt   <= '0;
    end else begin
      if (push) begin
        wrptr <= (wrptr == PTR_LAST) ? '0 : wrptr + 1'b1;
      end
      if (pop) begin
        rdptr <= (rdptr == PTR_LAST) ? '0 : rdptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef POWLIB_SFIFO_ERR_EN
  // Sticky overflow: write attempted while full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (wrvld && !wrrdy) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_powlib_sfifo.sv
// Testbench for powlib_sfifo (W=8, D=5): queue-based reference model,
// per-cycle compare process, directed scenarios plus randomized traffic.
module tb_powlib_sfifo;

  localparam int W = 8;
  localparam int D = 5;

  logic         clk;
  logic         rst;
  logic         clr;
  logic [W-1:0] wrdata;
  logic         wrvld;
  logic         wrrdy;
  logic [W-1:0] rddata;
  logic         rdvld;
  logic         rdrdy;
  logic [3:0]   cnt;
  logic         afull;
  logic         aempty;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  logic [W-1:0] q[$];
  bit           m_err;

  powlib_sfifo #(.W(W), .D(D)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
    .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy),
    .cnt(cnt), .afull(afull), .aempty(aempty), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, updated per the handshake rules
  always @(posedge clk or negedge rst) begin
    bit do_push;
    bit do_pop;
    if (!rst) begin
      q.delete();
      m_err = 0;
    end else if (clr) begin
      q.delete();
      m_err = 0;
    end else begin
      do_push = wrvld && (q.size() < D);
      do_pop  = rdrdy && (q.size() > 0);
      if (wrvld && q.size() == D) m_err = 1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(wrdata);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int sz;
    if (chk_en) begin
      sz = q.size();
      chk("wrrdy", {31'b0, wrrdy}, {31'b0, (rst && sz != D)});
      chk("rdvld", {31'b0, rdvld}, {31'b0, (rst && sz != 0)});
      chk("cnt", {28'b0, cnt}, 32'(sz));
      chk("afull", {31'b0, afull}, {31'b0, (sz >= D - 1)});
      chk("aempty", {31'b0, aempty}, {31'b0, (sz <= 1)});
`ifdef POWLIB_SFIFO_ERR_EN
      chk("err", {31'b0, err}, {31'b0, m_err});
`else
      chk("err", {31'b0, err}, 32'd0);
`endif
      if (rst && sz != 0) chk("rddata", {24'b0, rddata}, {24'b0, q[0]});
    end
  end

  // One cycle of stimulus; entered and left just after a falling edge
  task automatic cyc(input bit wv, input logic [W-1:0] wd, input bit rr, input bit cl);
    wrvld  = wv;
    wrdata = wd;
    rdrdy  = rr;
    clr    = cl;
    @(posedge clk);
    #1;
    wrvld = 0;
    rdrdy = 0;
    clr   = 0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    rst = 0; clr = 0; wrvld = 0; rdrdy = 0; wrdata = '0;
    #2;
    chk("rst_cnt", {28'b0, cnt}, 32'd0);
    chk("rst_wrrdy", {31'b0, wrrdy}, 32'd0);
    chk("rst_rdvld", {31'b0, rdvld}, 32'd0);
    chk("rst_afull", {31'b0, afull}, 32'd0);
    chk("rst_aempty", {31'b0, aempty}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk); #1;
    rst = 1;
    chk_en = 1;
    @(posedge clk); #1;
    chk("wrrdy_after_rst", {31'b0, wrrdy}, 32'd1);
    @(negedge clk); #1;

    // Fill to full with 0x01..0x05
    for (int i = 1; i <= D; i++) begin
      cyc(1, W'(i), 0, 0);
      if (i == 4) chk("afull_at4", {31'b0, afull}, 32'd1);
      if (i == 3) chk("afull_at3", {31'b0, afull}, 32'd0);
    end
    chk("full_cnt", {28'b0, cnt}, 32'd5);
    chk("full_wrrdy", {31'b0, wrrdy}, 32'd0);

    // Write and read while full: pop only, write dropped
    cyc(1, 8'hEE, 1, 0);
    chk("ovf_cnt", {28'b0, cnt}, 32'd4);
`ifdef POWLIB_SFIFO_ERR_EN
    chk("ovf_err", {31'b0, err}, 32'd1);
`else
    chk("ovf_err", {31'b0, err}, 32'd0);
`endif

    // Drain: remaining 0x02..0x05 in order
    for (int i = 2; i <= D; i++) begin
      chk("drain_data", {24'b0, rddata}, 32'(i));
      cyc(0, '0, 1, 0);
    end
    chk("empty_rdvld", {31'b0, rdvld}, 32'd0);
    chk("empty_aempty", {31'b0, aempty}, 32'd1);

    // Write and read while empty: push only
    cyc(1, 8'h77, 1, 0);
    chk("emp_pp_cnt", {28'b0, cnt}, 32'd1);
    chk("emp_pp_data", {24'b0, rddata}, 32'h77);
    cyc(1, 8'h10, 0, 0);

    // Sustained push+pop at cnt=2 across pointer wrap
    d = 8'h20;
    for (int i = 0; i < 12; i++) begin
      cyc(1, d, 1, 0);
      d = d + 1;
    end
    chk("steady_cnt", {28'b0, cnt}, 32'd2);
    chk("steady_head", {24'b0, rddata}, 32'h2A);

    // clr with concurrent write at cnt=3
    cyc(1, 8'h55, 0, 0);
    chk("pre_clr_cnt", {28'b0, cnt}, 32'd3);
    cyc(1, 8'h66, 0, 1);
    chk("clr_cnt", {28'b0, cnt}, 32'd0);
    chk("clr_rdvld", {31'b0, rdvld}, 32'd0);
    chk("clr_err", {31'b0, err}, 32'd0);
    cyc(1, 8'hAA, 0, 0);
    chk("post_clr_data", {24'b0, rddata}, 32'hAA);
    cyc(0, '0, 1, 0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) < 60), W'($urandom), ($urandom_range(99) < 55),
          ($urandom_range(99) == 0));
    end

    // Asynchronous reset between edges at cnt=3
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, W'(8'hC0 + i), 0, 0);
    chk("pre_rst_cnt", {28'b0, cnt}, 32'd3);
    #2;
    rst = 0;
    #1;
    chk("arst_cnt", {28'b0, cnt}, 32'd0);
    chk("arst_rdvld", {31'b0, rdvld}, 32'd0);
    chk("arst_wrrdy", {31'b0, wrrdy}, 32'd0);
    @(negedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("arst_release_wrrdy", {31'b0, wrrdy}, 32'd1);
    @(negedge clk); #1;
    cyc(1, 8'h3C, 0, 0);
    chk("arst_push_data", {24'b0, rddata}, 32'h3C);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/powlib_sfifo.md
# powlib_sfifo

Single-clock, parametrised-depth FIFO built on a dual-port memory with valid/ready handshakes on both sides, occupancy count and programmable almost-full/almost-empty flags. It is the general buffering primitive between pipelined stages in one clock domain and supersedes ad-hoc pipe/counter pairs wherever back-pressure is needed. Depth is not restricted to powers of two.

## Interface
- W, 32, data width in bits
- D, 8, depth in entries; D >= 2, any integer
- WIDX, powlib_clogb2(D), pointer width
- AFULL, D-1, afull asserted when count >= AFULL (1..D)
- AEMPTY, 1, aempty asserted when count <= AEMPTY (0..D-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush: pointers and count to 0, err cleared
- wrdata  in  W  write data
- wrvld  in  1  write request
- wrrdy  out  1  FIFO can accept (not full)
- rddata  out  W  head-of-FIFO data, valid when rdvld=1
- rdvld  out  1  FIFO holds data (not empty)
- rdrdy  in  1  consumer accepts head
- cnt  out  WIDX+1  current occupancy, 0..D
- afull  out  1  cnt >= AFULL
- aempty  out  1  cnt <= AEMPTY
- err  out  1  sticky overflow flag (see Configuration)

## Operation
- push = wrvld && wrrdy; pop = rdvld && rdrdy.
- wrrdy = (cnt != D) && rst deasserted; rdvld = (cnt != 0) && rst deasserted. Both derived from registered cnt only; no combinational path from wrvld/rdrdy to either.
- Push writes wrdata at wrptr; wrptr advances; wraps from D-1 to 0 (explicit compare, not modulo 2^WIDX).
- Pop advances rdptr with identical wrap rule.
- rddata = mem[rdptr] (show-ahead); don't-care when rdvld=0. Memory contents are not reset.
- cnt: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- Simultaneous push and pop legal at any non-empty, non-full level. When full, wrrdy=0 so no push even if pop occurs in the same cycle; when empty, rdvld=0 so no pop even if push occurs.
- clr has priority over push/pop in the same cycle: the push is discarded, cnt=0, wrptr=rdptr=0.
- afull/aempty are combinational decodes of registered cnt.

## Timing
- Reset (rst=0, asynchronous): wrptr=0, rdptr=0, cnt=0, err=0; wrrdy=0, rdvld=0, afull=0 (AFULL>=1), aempty=1.
- First edge after rst rises: wrrdy=1.
- Write-to-read latency: data pushed at edge k is visible with rdvld=1 after edge k (1 cycle) when FIFO was empty.
- Pop at edge k: rddata shows next entry after edge k.
- Throughput: one push and one pop per cycle sustained.
- Reset asserted mid-operation: all state cleared immediately; in-flight transfer on that edge is lost.

## Configuration
- Macro POWLIB_SFIFO_ERR_EN.
- Defined: err set on any edge where wrvld=1 and wrrdy=0 while rst deasserted; held until clr or rst.
- Undefined: err tied to 0, no detection logic synthesised; port remains.

## Test plan
- W=8, D=5: reset, push 0x01..0x05 back-to-back -> wrrdy drops after 5th push, cnt=5, afull=1 from cnt=4; pop all -> rddata 0x01..0x05 in order, rdvld drops, aempty=1.
- W=8, D=5: 12 cycles of simultaneous push/pop at cnt=2 with incrementing data -> cnt stays 2, order preserved across pointer wrap 4->0.
- Full FIFO (cnt=5), wrvld=1 and rdrdy=1 same cycle -> pop only, cnt=4, written word not stored; with POWLIB_SFIFO_ERR_EN err=1, without err=0.
- Empty FIFO, wrvld=1 and rdrdy=1 same cycle -> push only, cnt=1, rdvld=1 next cycle with that data.
- cnt=3, clr=1 with wrvld=1 -> next cycle cnt=0, rdvld=0, err=0; subsequent push 0xAA reads back 0xAA.
- rst driven low between edges with cnt=3 -> cnt=0, rdvld=0, wrrdy=0 immediately; wrrdy=1 after first edge following release.
